// File: rtl/dma_dsc_splitter.sv
// Command-to-descriptor splitter for one XDMA bypass direction: buffers (addr, len) commands
// and issues descriptors <= MAX_DSC_LEN. Define DMA_SPLIT_4K_EN to also stop at 4 KiB pages.
module dma_dsc_splitter #(
  parameter logic [31:0] MAX_DSC_LEN    = 32'h0001_0000,
  parameter int unsigned CMD_FIFO_DEPTH = 4
) (
  input  logic        pcie_clk,
  input  logic        pcie_areset,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [63:0] s_cmd_addr,
  input  logic [31:0] s_cmd_len,
  input  logic        dsc_byp_ready,
  output logic        dsc_byp_load,
  output logic [63:0] dsc_byp_addr,
  output logic [31:0] dsc_byp_len,
  output logic        cmd_done,
  output logic        busy,
  output logic [31:0] dsc_count
);

  localparam int unsigned AW = $clog2(CMD_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [63:0] fifo_addr [CMD_FIFO_DEPTH];
  logic [31:0] fifo_len  [CMD_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        run_q;
  logic [63:0] head_addr, cur_addr;
  logic [31:0] head_len, rem_len, chunk;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_addr  = fifo_addr[rd_ptr[AW-1:0]];
  assign head_len   = fifo_len[rd_ptr[AW-1:0]];

  // run_q holds ready low throughout reset and for the first edge after release
  assign s_cmd_ready = run_q && !fifo_full;
  assign push        = s_cmd_valid && s_cmd_ready;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign busy        = !fifo_empty || (state != IDLE);

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) begin
      run_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      run_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= s_cmd_addr;
      fifo_len[wr_ptr[AW-1:0]]  <= s_cmd_len;
    end
  end

  always_comb begin
    chunk = (rem_len > MAX_DSC_LEN) ? MAX_DSC_LEN : rem_len;
`ifdef DMA_SPLIT_4K_EN
    begin
      logic [31:0] page_room;
      page_room = {19'd0, 13'h1000 - {1'b0, cur_addr[11:0]}};
      if (chunk > page_room) chunk = page_room;
    end
`endif
  end

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    dsc_byp_load = 1'b0;
    cmd_done     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_len == '0) cmd_done  = 1'b1;
          else                state_nxt = CALC;
        end
      end
      CALC: state_nxt = ISSUE;
      ISSUE: begin
        if (dsc_byp_ready) begin
          dsc_byp_load = 1'b1;
          if (rem_len == dsc_byp_len) begin
            cmd_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) begin
      cur_addr     <= '0;
      rem_len      <= '0;
      dsc_byp_addr <= '0;
      dsc_byp_len  <= '0;
      dsc_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cur_addr <= head_addr;
            rem_len  <= head_len;
          end
        end
        CALC: begin
          dsc_byp_addr <= cur_addr;
          dsc_byp_len  <= chunk;
        end
        ISSUE: begin
          if (dsc_byp_load) begin
            cur_addr  <= cur_addr + {32'd0, dsc_byp_len};
            rem_len   <= rem_len - dsc_byp_len;
            dsc_count <= dsc_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
